// File: rtl/argmin_stream_out_pkg.sv
// argmin_stream_out_pkg: shared census/argmin defaults, entry flag layout and flag builder
package argmin_stream_out_pkg;
  localparam int COST_WIDTH_DEF = 8;
  localparam int DISP_WIDTH_DEF = 6;
  localparam int TREE_LATENCY_DEF = DISP_WIDTH_DEF;
  localparam int IMG_WIDTH_DEF = 320;
  localparam int IMG_HEIGHT_DEF = 240;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int FLAG_BITS = 5;
  typedef struct packed {
    logic conf;
    logic sol;
    logic eol;
    logic sof;
    logic eof;
  } flags_t;
  function automatic flags_t make_flags(input logic conf, input logic x_first, input logic x_last,
                                        input logic y_first, input logic y_last);
    return '{conf: conf, sol: x_first, eol: x_last, sof: x_first & y_first, eof: x_last & y_last};
  endfunction
endpackage

// File: rtl/argmin_stream_out_stream_fifo.sv
// stream_fifo: first-word-fall-through FIFO (push_i/wdata_i in, pop_i/rdata_o/valid_o out, full_o) with registered count
module stream_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             valid_o,
  output logic             full_o
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q, wr_d, rd_d;
  logic [CW-1:0] count_q, count_d;
  assign valid_o = count_q != '0;
  assign full_o = count_q == CW'(DEPTH);
  assign rdata_o = valid_o ? mem_q[rd_q] : '0;
  always_comb begin
    wr_d = push_i ? wr_q + AW'(1) : wr_q;
    rd_d = pop_i ? rd_q + AW'(1) : rd_q;
    count_d = count_q + CW'(push_i) - CW'(pop_i);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= wdata_i;
  end
endmodule

// File: rtl/argmin_stream_out.sv
// argmin_stream_out: tracks validity through the en-gated argmin tree, thresholds cost, tags sol/eol/sof/eof, streams out via FIFO and drives tree_en
module argmin_stream_out
  import argmin_stream_out_pkg::*;
#(
  parameter int COST_WIDTH = COST_WIDTH_DEF,
  parameter int DISP_WIDTH = DISP_WIDTH_DEF,
  parameter int TREE_LATENCY = TREE_LATENCY_DEF,
  parameter int IMG_WIDTH = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  tree_en,
  input  logic [COST_WIDTH-1:0] min_cost,
  input  logic [DISP_WIDTH-1:0] min_disp,
  input  logic [COST_WIDTH-1:0] cost_thresh,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DISP_WIDTH-1:0] out_disp,
  output logic                  out_conf,
  output logic                  out_sol,
  output logic                  out_eol,
  output logic                  out_sof,
  output logic                  out_eof
);
  localparam int EW = DISP_WIDTH + FLAG_BITS;
  localparam int XW = $clog2(IMG_WIDTH + 1);
  localparam int YW = $clog2(IMG_HEIGHT + 1);
  logic [TREE_LATENCY-1:0] vpipe_q, vpipe_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic push, pop, full, conf, x_last, y_last;
  logic [DISP_WIDTH-1:0] disp_w;
  flags_t flags, out_flags;
  logic [EW-1:0] wdata, rdata;
  assign tree_en = ~full;
  assign push = tree_en & vpipe_q[TREE_LATENCY-1];
  assign pop = out_valid & out_ready;
  assign conf = min_cost <= cost_thresh;
  assign x_last = x_q == XW'(IMG_WIDTH - 1);
  assign y_last = y_q == YW'(IMG_HEIGHT - 1);
  assign flags = make_flags(conf, x_q == '0, x_last, y_q == '0, y_last);
  assign disp_w = conf ? min_disp : '0;
  assign wdata = {disp_w, flags};
  assign {out_disp, out_flags} = rdata;
  assign out_conf = out_flags.conf;
  assign out_sol = out_flags.sol;
  assign out_eol = out_flags.eol;
  assign out_sof = out_flags.sof;
  assign out_eof = out_flags.eof;
  always_comb begin
    vpipe_d = tree_en ? (vpipe_q << 1) | TREE_LATENCY'(in_valid) : vpipe_q;
    x_d = !push ? x_q : x_last ? '0 : x_q + XW'(1);
    y_d = !(push & x_last) ? y_q : y_last ? '0 : y_q + YW'(1);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vpipe_q <= '0;
      x_q <= '0;
      y_q <= '0;
    end else begin
      vpipe_q <= vpipe_d;
      x_q <= x_d;
      y_q <= y_d;
    end
  end
  stream_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(push),
    .wdata_i(wdata),
    .pop_i(pop),
    .rdata_o(rdata),
    .valid_o(out_valid),
    .full_o(full)
  );
endmodule

// File: tb/tb_argmin_stream_out.sv
// tb_argmin_stream_out: directed scoreboard bench with a behavioural en-gated tree feeding the root
module tb_argmin_stream_out;
  localparam int CW = 8, DW = 6, TL = 3, IW = 4, IH = 2, FD = 4;
  logic clk = 0, rst = 0, in_valid = 0, out_ready = 1;
  logic tree_en, out_valid, out_conf, out_sol, out_eol, out_sof, out_eof;
  logic [CW-1:0] min_cost = '0, cost_thresh = 8'd9, in_cost = '0;
  logic [DW-1:0] min_disp = '0, in_disp = '0, out_disp;
  logic [CW-1:0] pc [TL];
  logic [DW-1:0] pd [TL];
  logic [DW+4:0] sb [$];
  int tests = 0, fails = 0, ex = 0, ey = 0, accepted = 0;
  always #5 clk = ~clk;
  argmin_stream_out #(
    .COST_WIDTH(CW), .DISP_WIDTH(DW), .TREE_LATENCY(TL),
    .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .tree_en(tree_en),
    .min_cost(min_cost), .min_disp(min_disp), .cost_thresh(cost_thresh),
    .out_valid(out_valid), .out_ready(out_ready), .out_disp(out_disp),
    .out_conf(out_conf), .out_sol(out_sol), .out_eol(out_eol),
    .out_sof(out_sof), .out_eof(out_eof)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [DW+4:0] observed();
    return {out_disp, out_conf, out_sol, out_eol, out_sof, out_eof};
  endfunction
  task automatic cycle();
    logic en_s, c, sol, eol;
    @(negedge clk);
    if (out_valid && out_ready) begin
      check("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) check("entry", 32'(observed()), 32'(sb.pop_front()));
    end
    en_s = tree_en;
    if (rst && tree_en && in_valid) begin
      c = in_cost <= cost_thresh;
      sol = ex == 0;
      eol = ex == IW - 1;
      sb.push_back({c ? in_disp : DW'(0), c, sol, eol, sol && ey == 0, eol && ey == IH - 1});
      if (eol) begin
        ex = 0;
        ey = (ey == IH - 1) ? 0 : ey + 1;
      end else ex++;
      accepted++;
    end
    @(posedge clk);
    if (en_s && rst) begin
      for (int i = TL - 1; i > 0; i--) begin
        pc[i] = pc[i-1];
        pd[i] = pd[i-1];
      end
      pc[0] = in_cost;
      pd[0] = in_disp;
    end
    #1;
    min_cost = pc[TL-1];
    min_disp = pd[TL-1];
  endtask
  task automatic do_reset();
    rst = 0;
    sb.delete();
    ex = 0;
    ey = 0;
    for (int i = 0; i < TL; i++) begin
      pc[i] = '0;
      pd[i] = '0;
    end
    min_cost = '0;
    min_disp = '0;
    repeat (2) cycle();
    rst = 1;
  endtask
  task automatic send(input logic [CW-1:0] c, input logic [DW-1:0] d);
    in_valid = 1;
    in_cost = c;
    in_disp = d;
    cycle();
    in_valid = 0;
  endtask
  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 20) begin
      cycle();
      n++;
    end
    check(tag, 32'(out_valid), 1);
  endtask
  task automatic drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 60) begin
      cycle();
      n++;
    end
    check(tag, 32'(sb.size()), 0);
    check({tag, "_idle"}, 32'(out_valid), 0);
  endtask
  initial begin
    do_reset();
    repeat (20) cycle();
    check("t1_valid", 32'(out_valid), 0);
    check("t1_en", 32'(tree_en), 1);
    check("t1_data", 32'(observed()), 0);
    check("t1_sb", 32'(sb.size()), 0);
    send(8'd5, 6'd17);
    check("t2_lat1", 32'(out_valid), 0);
    cycle();
    cycle();
    check("t2_lat3", 32'(out_valid), 0);
    cycle();
    check("t2_lat4", 32'(out_valid), 1);
    check("t2_disp", 32'(out_disp), 17);
    check("t2_conf", 32'(out_conf), 1);
    check("t2_sol", 32'(out_sol), 1);
    check("t2_sof", 32'(out_sof), 1);
    drain("t2_drain");
    send(8'd10, 6'd33);
    wait_valid("t3_valid");
    check("t3_disp", 32'(out_disp), 0);
    check("t3_conf", 32'(out_conf), 0);
    drain("t3_drain");
    send(8'd9, 6'd12);
    wait_valid("t3b_valid");
    check("t3b_disp", 32'(out_disp), 12);
    check("t3b_conf", 32'(out_conf), 1);
    drain("t3b_drain");
    do_reset();
    for (int i = 0; i < 9; i++) begin
      in_valid = 1;
      in_cost = CW'(i * 3);
      in_disp = DW'(i + 1);
      cycle();
    end
    in_valid = 0;
    drain("t4_drain");
    accepted = 0;
    out_ready = 0;
    for (int i = 0; i < 15; i++) begin
      in_valid = 1;
      in_cost = i[0] ? 8'd3 : 8'd20;
      in_disp = DW'(i + 40);
      cycle();
    end
    check("t5_accepted", 32'(accepted), TL + FD);
    check("t5_en_low", 32'(tree_en), 0);
    check("t5_valid", 32'(out_valid), 1);
    check("t5_head", 32'(observed()), 32'(sb[0]));
    in_valid = 0;
    out_ready = 1;
    check("t5_en_before_pop", 32'(tree_en), 0);
    cycle();
    check("t5_en_after_pop", 32'(tree_en), 1);
    drain("t5_drain");
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1;
      in_cost = 8'd4;
      in_disp = DW'(i + 5);
      cycle();
    end
    in_valid = 0;
    repeat (6) cycle();
    check("t6_buffered", 32'(out_valid), 1);
    #2 rst = 0;
    #1;
    check("t6_async_valid", 32'(out_valid), 0);
    check("t6_async_en", 32'(tree_en), 1);
    check("t6_async_data", 32'(observed()), 0);
    do_reset();
    out_ready = 1;
    send(8'd2, 6'd7);
    wait_valid("t6_valid");
    check("t6_sof", 32'(out_sof), 1);
    check("t6_disp", 32'(out_disp), 7);
    drain("t6_drain");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
